// File: rtl/life_gen_sequencer.sv
// Purpose: raster-sweeps a GRID_W x GRID_H grid once per generation and then flips the ping-pong buffer.
// Latency: first address one cycle after start; SWAP follows the final writeback edge, so one generation takes cells+1 cycles at best.
// Backpressure: addr_valid/addr_ready; the address holds while ready is low, and DRAIN waits for outstanding writebacks.
module life_gen_sequencer #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int X_BITS   = 6,
    parameter int Y_BITS   = 6,
    parameter int GEN_BITS = 16,
    parameter int CNT_BITS = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                step_i,
    input  logic                run_i,
    output logic                busy_o,
    output logic [X_BITS-1:0]   addr_x_o,
    output logic [Y_BITS-1:0]   addr_y_o,
    output logic                addr_valid_o,
    input  logic                addr_ready_i,
    output logic                addr_last_o,
    input  logic                wb_valid_i,
    output logic                buf_sel_o,
    output logic [GEN_BITS-1:0] generation_o,
    output logic                gen_done_o,
    output logic                err_o
);

    localparam logic [X_BITS-1:0]   X_MAX = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0]   Y_MAX = Y_BITS'(GRID_H - 1);
    localparam logic [CNT_BITS-1:0] CELLS = CNT_BITS'(GRID_W * GRID_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [X_BITS-1:0]   x_q, x_d;
    logic [Y_BITS-1:0]   y_q, y_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [GEN_BITS-1:0] gen_q, gen_d;
    logic                pending_q, pending_d;
    logic                buf_sel_q, buf_sel_d;
    logic                err_q, err_d;

    logic                at_last;
    logic                accept;
    logic                wb_take;
    logic                wb_stray;
    logic [CNT_BITS-1:0] cnt_inc;

    // Qualify the handshake and decide whether this cycle's writeback is counted or is an error.
    always_comb begin
        at_last  = (x_q == X_MAX) && (y_q == Y_MAX);
        accept   = (state_q == SWEEP) && addr_ready_i;
        wb_take  = wb_valid_i && ((state_q == SWEEP) || (state_q == DRAIN)) && (cnt_q != CELLS);
        wb_stray = wb_valid_i && !wb_take;
        cnt_inc  = cnt_q + {{(CNT_BITS-1){1'b0}}, wb_take};
    end

    // Next-state logic: sweep addresses, count writebacks, and complete the generation in SWAP.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        gen_d     = gen_q;
        buf_sel_d = buf_sel_q;
        // A step that arrives mid-generation is remembered; repeats collapse into one request.
        pending_d = pending_q | (step_i & (state_q != IDLE));
        err_d     = err_q | wb_stray;

        case (state_q)
            IDLE: begin
                if (step_i || run_i || pending_q) begin
                    state_d   = SWEEP;
                    pending_d = 1'b0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_inc;
                if (accept) begin
                    if (at_last) begin
                        x_d = '0;
                        y_d = '0;
                        // Zero-latency rule engines deliver the final writeback on the last accept.
                        state_d = (cnt_inc == CELLS) ? SWAP : DRAIN;
                    end else if (x_q == X_MAX) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_inc;
                if (cnt_inc == CELLS) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                buf_sel_d = ~buf_sel_q;
                gen_d     = gen_q + 1'b1;
                cnt_d     = '0;
                if (run_i || pending_q) begin
                    state_d   = SWEEP;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any generation in flight, including buffer select and count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            gen_q     <= '0;
            pending_q <= 1'b0;
            buf_sel_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            gen_q     <= gen_d;
            pending_q <= pending_d;
            buf_sel_q <= buf_sel_d;
            err_q     <= err_d;
        end
    end

    // Outputs are decoded from registered state only; no input reaches an output combinationally.
    assign busy_o       = (state_q != IDLE);
    assign addr_valid_o = (state_q == SWEEP);
    assign addr_last_o  = (state_q == SWEEP) && at_last;
    assign addr_x_o     = x_q;
    assign addr_y_o     = y_q;
    assign gen_done_o   = (state_q == SWAP);
    assign buf_sel_o    = buf_sel_q;
    assign generation_o = gen_q;
    assign err_o        = err_q;

endmodule
